didactic_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/didactic_uart_tx.sv | 121 ++++++++++++
 tb/tb_didactic_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the Didactic UART: frame constants, the transmitter
// state encoding and the parity helper.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with push/pop, full/empty flags and an explicit
// occupancy counter so full and empty never alias.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            pop_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok, pop_ok;

  // Writes while full and reads while empty are silently dropped.
  assign full_o     = (level_q == LW'(FIFO_DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Pointer and occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array: written on an accepted push, contents are not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/didactic_uart_tx.sv
// Buffered UART transmitter: byte FIFO in front of a start/data/parity/stop
// serialiser with a per-frame latched baud divisor.
module didactic_uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIV_WIDTH-1:0]         baud_div_i,
  input  logic [7:0]                   tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic                         uart_tx_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  uart_tx_state_t              state_q, state_d;
  logic [DIV_WIDTH-1:0]        baud_cnt_q, div_q;
  logic [2:0]                  bit_cnt_q;
  logic [UART_DATA_BITS-1:0]   shift_q;
  logic                        parity_q;
  logic                        line_q, line_d;
  logic                        bit_end, last_stop, load;
  logic                        fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_head;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tx_valid_i),
    .push_data_i (tx_data_i),
    .pop_i       (load),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  assign bit_end    = (baud_cnt_q == div_q);
  assign last_stop  = (state_q == ST_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
  assign tx_ready_o = !fifo_full;
  assign uart_tx_o  = line_q;
  assign busy_o     = (state_q != ST_IDLE) || (fifo_level_o != '0);

  // State register plus the registered serial line; reset forces the line idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      line_q  <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic; the last stop bit chains straight into the next start bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt_q == LAST_DATA)
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (last_stop) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: FIFO pop strobe and the line level for the current state.
  always_comb begin
    load   = !fifo_empty && ((state_q == ST_IDLE) || last_stop);
    line_d = UART_IDLE_LEVEL;
    case (state_q)
      ST_IDLE:   line_d = UART_IDLE_LEVEL;
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
      ST_PARITY: line_d = parity_q;
      ST_STOP:   line_d = 1'b1;
      default:   line_d = UART_IDLE_LEVEL;
    endcase
  end

  // Bit timer and bit counter; the bit counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE || bit_end) baud_cnt_q <= '0;
      else                               baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
      if (state_d != state_q)                 bit_cnt_q <= '0;
      else if (bit_end && state_q != ST_IDLE) bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  // Frame datapath: byte, divisor and parity captured at pop, then shifted LSB-first.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q  <= fifo_head;
      div_q    <= baud_div_i;
      parity_q <= uart_parity(fifo_head, PAR_ODD);
    end else if (state_q == ST_DATA && bit_end) begin
      shift_q  <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_didactic_uart_tx.sv
// Bench for didactic_uart_tx: three configurations (plain 8N1, even parity with
// two stop bits, odd parity) driven from one shared input stream.
module tb_didactic_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        rdy0, line0, busy0;
  logic        rdy1, line1, busy1;
  logic        rdy2, line2, busy2;
  logic [3:0]  lvl0, lvl1, lvl2;

  always #5 clk = ~clk;

  didactic_uart_tx dut0 (
    .clk(clk), .reset(reset), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(rdy0), .uart_tx_o(line0),
    .busy_o(busy0), .fifo_level_o(lvl0));

  didactic_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(rdy1), .uart_tx_o(line1),
    .busy_o(busy1), .fifo_level_o(lvl1));

  didactic_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(rdy2), .uart_tx_o(line2),
    .busy_o(busy2), .fifo_level_o(lvl2));

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [11:0] e0;   // 8N1 frame, bit 0 = first bit on the line
    logic [11:0] e1;   // 8E2 frame
    logic [11:0] e2;   // 8O1 frame
  } vec_t;

  vec_t vecs [5];
  int   n_pass  = 0;
  int   n_total = 0;
  logic tr [0:2][0:511];
  logic bz [0:2][0:511];
  int   rec_idx = 0;
  bit   rec_on  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: wait for the falling edge, then log the lines of all three DUTs.
  task automatic tick();
    @(negedge clk);
    if (rec_on && rec_idx < 512) begin
      tr[0][rec_idx] = line0; tr[1][rec_idx] = line1; tr[2][rec_idx] = line2;
      bz[0][rec_idx] = busy0; bz[1][rec_idx] = busy1; bz[2][rec_idx] = busy2;
      rec_idx++;
    end
  endtask

  task automatic start_rec();
    rec_idx = 0;
    rec_on  = 1;
  endtask

  function automatic logic [11:0] frame10(input logic [7:0] b);
    return {2'b00, 1'b1, b, 1'b0};
  endfunction

  // Each bit cell must hold one constant level for its full d+1 cycles.
  task automatic chk_frame(input string name, input int dut, input logic [11:0] exp,
                           input int nbits, input int d, input int c0);
    logic [11:0] act;
    bit all1, all0;
    int idx;
    act = '0;
    for (int k = 0; k < nbits; k++) begin
      all1 = 1; all0 = 1;
      for (int j = 0; j <= d; j++) begin
        idx = c0 + k * (d + 1) + j;
        if (idx > 511 || tr[dut][idx] !== 1'b1) all1 = 0;
        if (idx > 511 || tr[dut][idx] !== 1'b0) all0 = 0;
      end
      act[k] = all1 ? 1'b1 : (all0 ? 1'b0 : ~exp[k]);
    end
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1 || busy2) && n < 6000) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy0 | busy1 | busy2), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d, n;
    bit   ok;
    logic [7:0] rx;
    logic start_low, stop_high;
    logic [7:0] msg [3];

    vecs[0] = '{8'h55, 16'd3, 12'h2AA, 12'hCAA, 12'h6AA};
    vecs[1] = '{8'h07, 16'd3, 12'h20E, 12'hE0E, 12'h40E};
    vecs[2] = '{8'hA3, 16'd0, 12'h346, 12'hD46, 12'h746};
    vecs[3] = '{8'hFF, 16'd1, 12'h3FE, 12'hDFE, 12'h7FE};
    vecs[4] = '{8'h80, 16'd2, 12'h300, 12'hF00, 12'h500};
    msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A;

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; baud_div = 16'd3;
    repeat (3) @(posedge clk);
    tick();
    reset = 1'b0;
    chk("reset_uart_tx", 32'(line0), 32'd1);
    chk("reset_ready",   32'(rdy0),  32'd1);
    chk("reset_busy",    32'(busy0), 32'd0);
    chk("reset_level",   32'(lvl0),  32'd0);
    tick();

    // Single-frame vectors across divisors and parity configurations
    for (int i = 0; i < 5; i++) begin
      d = int'(vecs[i].div);
      baud_div = vecs[i].div; tx_data = vecs[i].data; tx_valid = 1'b1;
      start_rec();
      tick();
      tx_valid = 1'b0;
      chk($sformatf("v%0d_level_after_push", i), 32'(lvl0), 32'd1);
      while (rec_idx <= 4 + 12 * (d + 1)) tick();
      rec_on = 0;
      chk($sformatf("v%0d_line_high_c1", i), 32'(tr[0][1]), 32'd1);
      chk_frame($sformatf("v%0d_8n1_frame", i), 0, vecs[i].e0, 10, d, 2);
      chk_frame($sformatf("v%0d_8e2_frame", i), 1, vecs[i].e1, 12, d, 2);
      chk_frame($sformatf("v%0d_8o1_frame", i), 2, vecs[i].e2, 11, d, 2);
      chk($sformatf("v%0d_busy_timing_8n1", i),
          32'({bz[0][10*(d+1)], bz[0][10*(d+1)+1]}), 32'b10);
      chk($sformatf("v%0d_busy_timing_8e2", i),
          32'({bz[1][12*(d+1)], bz[1][12*(d+1)+1]}), 32'b10);
      chk($sformatf("v%0d_busy_timing_8o1", i),
          32'({bz[2][11*(d+1)], bz[2][11*(d+1)+1]}), 32'b10);
      wait_idle();
    end

    // Burst of nine bytes into an eight-deep FIFO
    baud_div = 16'd1;
    for (int k = 0; k < 9; k++) begin
      tx_data = 8'(k); tx_valid = 1'b1;
      if (k == 0) start_rec();
      n = 0;
      while (!rdy0 && n < 50) begin tick(); n++; end
      tick();
    end
    chk("burst_level_full", 32'(lvl0), 32'd8);
    chk("burst_ready_low",  32'(rdy0), 32'd0);
    tx_data = 8'hEE;
    repeat (3) tick();
    tx_valid = 1'b0;
    chk("full_push_ignored_level", 32'(lvl0), 32'd8);
    while (rec_idx <= 186) tick();
    rec_on = 0;
    for (int f = 0; f < 9; f++)
      chk_frame($sformatf("burst_frame%0d", f), 0, frame10(8'(f)), 10, 1, 2 + f * 20);
    chk("burst_idle_after", 32'(tr[0][182] & tr[0][183] & tr[0][184] & tr[0][185]), 32'd1);
    chk("burst_busy_end", 32'({bz[0][180], bz[0][181]}), 32'b10);
    wait_idle();

    // Divisor change during data bit 4 only affects the following frame
    baud_div = 16'd3; tx_data = 8'h5A; tx_valid = 1'b1;
    start_rec();
    tick();
    tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0;
    while (rec_idx <= 23) tick();
    baud_div = 16'd7;
    while (rec_idx <= 126) tick();
    rec_on = 0;
    chk_frame("divchg_frame_old_div", 0, frame10(8'h5A), 10, 3, 2);
    chk_frame("divchg_frame_new_div", 0, frame10(8'hC3), 10, 7, 42);
    chk("divchg_idle_after", 32'(tr[0][122] & tr[0][123] & tr[0][124] & tr[0][125]), 32'd1);
    wait_idle();

    // "OK\n" at 115200 baud from an 8 MHz clock, decoded by a mid-bit sampler
    baud_div = 16'd68;
    for (int b = 0; b < 3; b++) begin
      tx_data = msg[b]; tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (line0 !== 1'b0 && n < 3000) begin tick(); n++; end
      repeat (34) tick();
      start_low = ~line0;
      rx = '0;
      for (int k = 0; k < 8; k++) begin
        repeat (69) tick();
        rx[k] = line0;
      end
      repeat (69) tick();
      stop_high = line0;
      chk($sformatf("rx_byte%0d", b), 32'(rx), 32'(msg[b]));
      chk($sformatf("rx_framing%0d", b), 32'({start_low, stop_high}), 32'b11);
    end
    wait_idle();

    // Reset in the middle of a data bit with three bytes still queued
    baud_div = 16'd3; tx_valid = 1'b1;
    tx_data = 8'h11; start_rec(); tick();
    tx_data = 8'h22; tick();
    tx_data = 8'h33; tick();
    tx_data = 8'h44; tick();
    tx_valid = 1'b0;
    while (rec_idx <= 11) tick();
    chk("rst_precond_line_low", 32'(tr[0][11]), 32'd0);
    chk("rst_precond_level",    32'(lvl0),      32'd3);
    reset = 1'b1;
    tick();
    chk("rst_mid_uart_tx", 32'(line0), 32'd1);
    chk("rst_mid_level",   32'(lvl0),  32'd0);
    chk("rst_mid_ready",   32'(rdy0),  32'd1);
    chk("rst_mid_busy",    32'(busy0), 32'd0);
    reset = 1'b0;
    ok = 1;
    repeat (60) begin
      tick();
      if (line0 !== 1'b1 || busy0 !== 1'b0 || line1 !== 1'b1 || line2 !== 1'b1) ok = 0;
    end
    rec_on = 0;
    chk("rst_no_more_frames", 32'(ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
